d_output_arbiter: RTL and testbench

D_OUTPUT_ARBITER -- requirements
Module: d_output_arbiter

---
 rtl/d_output_arbiter.sv | 99 +++++++++
 tb/tb_d_output_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/d_output_arbiter.sv
// Two-source output arbiter: pops one word at a time from the D0/D1 FIFOs, holds it
// for the downstream sink, and counts accepted words per source.
module d_output_arbiter #(
   parameter int unsigned BITNUMBER = 8,
   localparam int unsigned CNT_W = 5
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 init,
   input  logic                 D0_can_pop,
   input  logic                 D1_can_pop,
   input  logic [BITNUMBER-1:0] D0_data_out,
   input  logic [BITNUMBER-1:0] D1_data_out,
   input  logic                 sink_ready,
   output logic                 pop_D0,
   output logic                 pop_D1,
   output logic [BITNUMBER-1:0] data_out,
   output logic                 valid_out,
   output logic                 dest_out,
   output logic [CNT_W-1:0]     count_D0,
   output logic [CNT_W-1:0]     count_D1
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      POP     = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   state_t state;
   logic   sel;
   logic   last_grant;
   logic   pick_c;
   logic   accept_c;

   // Lone requester wins; on a tie the source that did not win last time goes next.
   assign pick_c   = (D0_can_pop && D1_can_pop) ? ~last_grant : D1_can_pop;
   assign accept_c = (state == HOLD) && sink_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         sel        <= 1'b0;
         last_grant <= 1'b1;
         pop_D0     <= 1'b0;
         pop_D1     <= 1'b0;
         data_out   <= '0;
         valid_out  <= 1'b0;
         dest_out   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (D0_can_pop || D1_can_pop) begin
                  sel    <= pick_c;
                  pop_D0 <= ~pick_c;
                  pop_D1 <= pick_c;
                  state  <= POP;
               end
            end
            POP: begin
               pop_D0 <= 1'b0;
               pop_D1 <= 1'b0;
               state  <= CAPTURE;
            end
            CAPTURE: begin
               data_out  <= sel ? D1_data_out : D0_data_out;
               dest_out  <= sel;
               valid_out <= 1'b1;
               state     <= HOLD;
            end
            HOLD: begin
               if (sink_ready) begin
                  valid_out  <= 1'b0;
                  last_grant <= dest_out;
                  state      <= IDLE;
               end
            end
            default: begin
               pop_D0 <= 1'b0;
               pop_D1 <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

   // Accepted-word counters; init clears them and beats a coincident increment.
   always_ff @(posedge clk) begin
      if (reset || init) begin
         count_D0 <= '0;
         count_D1 <= '0;
      end else if (accept_c) begin
         if (dest_out) count_D1 <= count_D1 + CNT_W'(1);
         else          count_D0 <= count_D0 + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_d_output_arbiter.sv
// Self-checking bench for d_output_arbiter: directed vector table, corner-case
// sequences, and a randomized run against a transaction-age reference model.
module tb_d_output_arbiter;

   logic       clk = 1'b0;
   logic       reset, init, D0_can_pop, D1_can_pop, sink_ready;
   logic [7:0] D0_data_out, D1_data_out;
   logic       pop_D0, pop_D1, valid_out, dest_out;
   logic [7:0] data_out;
   logic [4:0] count_D0, count_D1;

   int n_cmp = 0;
   int n_bad = 0;

   d_output_arbiter #(.BITNUMBER(8)) dut (
      .clk(clk), .reset(reset), .init(init),
      .D0_can_pop(D0_can_pop), .D1_can_pop(D1_can_pop),
      .D0_data_out(D0_data_out), .D1_data_out(D1_data_out),
      .sink_ready(sink_ready),
      .pop_D0(pop_D0), .pop_D1(pop_D1), .data_out(data_out),
      .valid_out(valid_out), .dest_out(dest_out),
      .count_D0(count_D0), .count_D1(count_D1)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic       rst, ini, c0, c1;
      logic [7:0] d0, d1;
      logic       snk;
      logic       e_p0, e_p1, e_v;
      logic [7:0] e_d;
      logic       e_dest;
      logic [4:0] e_c0, e_c1;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic rst, ini, c0, c1, input logic [7:0] d0, d1,
                               input logic snk, p0, p1, v, input logic [7:0] d,
                               input logic dst, input logic [4:0] k0, k1);
      vec_t r;
      r.rst = rst; r.ini = ini; r.c0 = c0; r.c1 = c1; r.d0 = d0; r.d1 = d1; r.snk = snk;
      r.e_p0 = p0; r.e_p1 = p1; r.e_v = v; r.e_d = d; r.e_dest = dst; r.e_c0 = k0; r.e_c1 = k1;
      return r;
   endfunction

   function automatic logic [21:0] outs();
      return {pop_D0, pop_D1, valid_out, data_out, dest_out, count_D0, count_D1};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Advance until valid_out rises, checking pop exclusivity every cycle.
   task automatic wait_valid(input string name, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("pop_exclusive", 32'(pop_D0 & pop_D1), 32'd0);
         if (valid_out) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: valid_out never rose within 12 cycles", name);
      end
   endtask

   // Reference model: a word is tracked by its age in edges since the grant.
   bit         m_busy, m_src, m_lg, m_dest;
   int         m_age, m_c0, m_c1;
   logic [7:0] m_data;

   task automatic model_step();
      if (reset) begin
         m_busy = 0; m_age = 0; m_lg = 1; m_data = 8'h00; m_dest = 0; m_c0 = 0; m_c1 = 0;
      end else begin
         if (!m_busy) begin
            if (D0_can_pop || D1_can_pop) begin
               m_src  = (D0_can_pop && D1_can_pop) ? !m_lg : D1_can_pop;
               m_busy = 1;
               m_age  = 0;
            end
         end else if (m_age >= 2 && sink_ready) begin
            m_busy = 0;
            if (m_dest) m_c1 = (m_c1 + 1) % 32;
            else        m_c0 = (m_c0 + 1) % 32;
            m_lg = m_dest;
         end else begin
            if (m_age == 1) begin
               m_data = m_src ? D1_data_out : D0_data_out;
               m_dest = m_src;
            end
            if (m_age < 2) m_age++;
         end
         if (init) begin
            m_c0 = 0;
            m_c1 = 0;
         end
      end
   endtask

   function automatic logic [21:0] model_outs();
      logic p0, p1, v;
      p0 = m_busy && m_age == 0 && !m_src;
      p1 = m_busy && m_age == 0 && m_src;
      v  = m_busy && m_age >= 2;
      return {p0, p1, v, m_data, m_dest, 5'(m_c0), 5'(m_c1)};
   endfunction

   initial begin
      bit ok;
      reset = 1; init = 0; D0_can_pop = 0; D1_can_pop = 0; sink_ready = 0;
      D0_data_out = 8'h00; D1_data_out = 8'h00;

      // rst ini c0 c1 d0 d1 snk | p0 p1 v data dest c0 c1
      vt.push_back(mk(1,0,0,0,8'hA5,8'h00,1, 0,0,0,8'h00,0,0,0));
      vt.push_back(mk(1,0,1,0,8'hA5,8'h00,1, 0,0,0,8'h00,0,0,0));
      vt.push_back(mk(0,0,1,0,8'hA5,8'h00,1, 1,0,0,8'h00,0,0,0));
      vt.push_back(mk(0,0,1,0,8'hA5,8'h00,1, 0,0,0,8'h00,0,0,0));
      vt.push_back(mk(0,0,0,0,8'hA5,8'h00,1, 0,0,1,8'hA5,0,0,0));
      vt.push_back(mk(0,0,0,0,8'hA5,8'h00,1, 0,0,0,8'hA5,0,1,0));
      vt.push_back(mk(0,0,0,0,8'h3C,8'h00,0, 0,0,0,8'hA5,0,1,0));
      vt.push_back(mk(0,0,1,0,8'h3C,8'h00,0, 1,0,0,8'hA5,0,1,0));
      vt.push_back(mk(0,0,1,0,8'h3C,8'h00,0, 0,0,0,8'hA5,0,1,0));
      vt.push_back(mk(0,0,1,0,8'h3C,8'h00,0, 0,0,1,8'h3C,0,1,0));
      for (int i = 0; i < 4; i++)
         vt.push_back(mk(0,0,1,0,8'h11,8'h00,0, 0,0,1,8'h3C,0,1,0));
      vt.push_back(mk(0,0,1,0,8'h11,8'h00,1, 0,0,0,8'h3C,0,2,0));
      vt.push_back(mk(0,0,0,1,8'h11,8'h77,0, 0,1,0,8'h3C,0,2,0));
      vt.push_back(mk(0,0,0,0,8'h11,8'h77,0, 0,0,0,8'h3C,0,2,0));
      vt.push_back(mk(0,0,0,0,8'h11,8'h77,0, 0,0,1,8'h77,1,2,0));
      vt.push_back(mk(0,1,0,0,8'h11,8'h77,1, 0,0,0,8'h77,1,0,0));
      vt.push_back(mk(0,0,1,1,8'h11,8'h77,0, 1,0,0,8'h77,1,0,0));
      vt.push_back(mk(0,1,1,1,8'h11,8'h77,0, 0,0,0,8'h77,1,0,0));
      vt.push_back(mk(0,0,0,0,8'h22,8'h77,0, 0,0,1,8'h22,0,0,0));

      foreach (vt[i]) begin
         reset = vt[i].rst; init = vt[i].ini; D0_can_pop = vt[i].c0; D1_can_pop = vt[i].c1;
         D0_data_out = vt[i].d0; D1_data_out = vt[i].d1; sink_ready = vt[i].snk;
         tick();
         chk($sformatf("vec%0d", i), 32'(outs()),
             32'({vt[i].e_p0, vt[i].e_p1, vt[i].e_v, vt[i].e_d, vt[i].e_dest, vt[i].e_c0, vt[i].e_c1}));
      end
      init = 0;

      // Round robin with both sources always ready.
      reset = 1; D0_can_pop = 0; D1_can_pop = 0; tick(); tick();
      reset = 0; D0_can_pop = 1; D1_can_pop = 1; sink_ready = 1;
      for (int w = 0; w < 4; w++) begin
         wait_valid("rr_valid", ok);
         if (ok) chk($sformatf("rr_dest%0d", w), 32'(dest_out), 32'(w % 2));
         tick();
      end
      D0_can_pop = 0; D1_can_pop = 0;
      chk("rr_count_D0", 32'(count_D0), 32'd2);
      chk("rr_count_D1", 32'(count_D1), 32'd2);

      // Counter wrap on a D1-only stream of 33 words.
      reset = 1; tick(); reset = 0;
      D1_can_pop = 1; sink_ready = 1;
      for (int w = 1; w <= 33; w++) begin
         D1_data_out = 8'(w);
         wait_valid("wrap_valid", ok);
         tick();
         if (w >= 31) chk($sformatf("wrap_count%0d", w), 32'(count_D1), 32'(w % 32));
      end
      D1_can_pop = 0;
      tick();

      // Reset while a word sits in CAPTURE discards it and pops nothing again.
      D0_can_pop = 1; D0_data_out = 8'h5A; sink_ready = 0;
      tick();
      chk("cap_pop", 32'(pop_D0), 32'd1);
      tick();
      reset = 1; D0_can_pop = 0;
      tick();
      reset = 0;
      chk("cap_reset", 32'(outs()), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("cap_no_repop", 32'({pop_D0, pop_D1, valid_out}), 32'd0);
      end

      // Randomized run against the reference model.
      for (int cyc = 0; cyc < 3000; cyc++) begin
         reset      = (cyc == 0) || ($urandom_range(149) == 0);
         init       = ($urandom_range(19) == 0);
         D0_can_pop = ($urandom_range(3) != 0);
         D1_can_pop = ($urandom_range(3) != 0);
         sink_ready = ($urandom_range(9) < 6);
         if ($urandom_range(7) == 0) begin
            D0_can_pop = 0;
            D1_can_pop = 0;
         end
         model_step();
         tick();
         chk("rand_outs", 32'(outs()), 32'(model_outs()));
         if (pop_D0) D0_data_out = 8'($urandom);
         if (pop_D1) D1_data_out = 8'($urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
